// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
// Package : mouse_pkg
// Brief   : Shared mouse register map, sample type and writer state encoding.
// Revision: 1.0
// ============================================================================
package mouse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR_X = 2'd1,
      ST_WR_Y = 2'd2,
      ST_WR_B = 2'd3
   } mw_state_t;

   localparam logic [3:0] MOUSE_X_OFS   = 4'd0;
   localparam logic [3:0] MOUSE_Y_OFS   = 4'd1;
   localparam logic [3:0] MOUSE_BTN_OFS = 4'd2;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [2:0]  btn;
   } mouse_sample_t;

   // Word addresses wrap within the 16-word register window.
   function automatic logic [3:0] mw_word_addr(input logic [3:0] base, input logic [3:0] ofs);
      return base + ofs;
   endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_mouse_writer_if.sv
`default_nettype none
// ============================================================================
// Interface : avalon_mouse_writer_if
// Brief     : Write-only Avalon-MM bus between the mouse writer and the slave.
// Revision  : 1.0
// ============================================================================
interface avalon_mouse_writer_if;

   logic        AVM_CS;
   logic        AVM_WRITE;
   logic [3:0]  AVM_ADDR;
   logic [31:0] AVM_WRITEDATA;
   logic [3:0]  AVM_BYTE_EN;
   logic        AVM_WAITREQUEST;

   modport master (
      output AVM_CS, AVM_WRITE, AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN,
      input  AVM_WAITREQUEST
   );

   modport slave (
      input  AVM_CS, AVM_WRITE, AVM_ADDR, AVM_WRITEDATA, AVM_BYTE_EN,
      output AVM_WAITREQUEST
   );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones, with synchronous clear.
// Revision: 1.0
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  wire logic             CLK,
   input  wire logic             clr,
   input  wire logic             inc,
   output logic      [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] c_one = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_max = '1;

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge CLK) begin
      if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != c_max)) begin
         r_count <= r_count + c_one;
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/avalon_mouse_writer.sv
`default_nettype none
// ============================================================================
// Module  : avalon_mouse_writer
// Brief   : Avalon-MM master writing each mouse sample as X, Y, buttons words.
// Revision: 1.0
// ============================================================================
module avalon_mouse_writer
   import mouse_pkg::*;
#(
   parameter logic [3:0] BASE_ADDR = 4'd0,
   parameter int         CNT_W     = 8
) (
   input  wire logic              CLK,
   input  wire logic              RESET,
   input  wire logic              IN_VALID,
   input  wire logic [15:0]       IN_X,
   input  wire logic [15:0]       IN_Y,
   input  wire logic [2:0]        IN_BTN,
   avalon_mouse_writer_if.master  avm,
   output logic                   BUSY,
   output logic      [CNT_W-1:0]  DROP_COUNT
);

   mw_state_t     r_state, w_state_nxt;
   mouse_sample_t r_shadow, w_shadow_nxt;
   mouse_sample_t r_pend, w_pend_nxt;
   mouse_sample_t w_in;
   logic          r_pend_v, w_pend_v_nxt;
   logic          w_drop;
   logic          w_done;
   logic          w_b_done;

   logic          r_write;
   logic [3:0]    r_addr, w_addr_nxt;
   logic [31:0]   r_wdata, w_wdata_nxt;
   logic [3:0]    r_byte_en;

   assign w_in     = {IN_X, IN_Y, IN_BTN};
   assign w_done   = (r_state != ST_IDLE) && !avm.AVM_WAITREQUEST;
   assign w_b_done = (r_state == ST_WR_B) && w_done;

   always_comb begin
      w_state_nxt   = r_state;
      w_shadow_nxt  = r_shadow;
      w_pend_nxt    = r_pend;
      w_pend_v_nxt  = r_pend_v;
      w_drop        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (IN_VALID) begin
               w_shadow_nxt = w_in;
               w_state_nxt  = ST_WR_X;
            end
         end
         ST_WR_X: if (w_done) w_state_nxt = ST_WR_Y;
         ST_WR_Y: if (w_done) w_state_nxt = ST_WR_B;
         ST_WR_B: begin
            if (w_done) begin
               // A fresh strobe beats anything still parked in pending.
               if (IN_VALID) begin
                  w_shadow_nxt = w_in;
                  w_state_nxt  = ST_WR_X;
                  w_drop       = r_pend_v;
                  w_pend_v_nxt = 1'b0;
               end else if (r_pend_v) begin
                  w_shadow_nxt = r_pend;
                  w_state_nxt  = ST_WR_X;
                  w_pend_v_nxt = 1'b0;
               end else begin
                  w_state_nxt  = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if ((r_state != ST_IDLE) && !w_b_done && IN_VALID) begin
         w_pend_nxt   = w_in;
         w_pend_v_nxt = 1'b1;
         w_drop       = r_pend_v;
      end
   end

   // Bus outputs are decoded from the next state so they leave a flop.
   always_comb begin
      w_addr_nxt  = 4'h0;
      w_wdata_nxt = 32'h0;
      case (w_state_nxt)
         ST_WR_X: begin
            w_addr_nxt  = mw_word_addr(BASE_ADDR, MOUSE_X_OFS);
            w_wdata_nxt = {16'h0, w_shadow_nxt.x};
         end
         ST_WR_Y: begin
            w_addr_nxt  = mw_word_addr(BASE_ADDR, MOUSE_Y_OFS);
            w_wdata_nxt = {16'h0, w_shadow_nxt.y};
         end
         ST_WR_B: begin
            w_addr_nxt  = mw_word_addr(BASE_ADDR, MOUSE_BTN_OFS);
            w_wdata_nxt = {29'h0, w_shadow_nxt.btn};
         end
         default: begin
            w_addr_nxt  = 4'h0;
            w_wdata_nxt = 32'h0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= ST_IDLE;
         r_shadow  <= '0;
         r_pend    <= '0;
         r_pend_v  <= 1'b0;
         r_write   <= 1'b0;
         r_addr    <= 4'h0;
         r_wdata   <= 32'h0;
         r_byte_en <= 4'h0;
      end else begin
         r_state   <= w_state_nxt;
         r_shadow  <= w_shadow_nxt;
         r_pend    <= w_pend_nxt;
         r_pend_v  <= w_pend_v_nxt;
         r_write   <= (w_state_nxt != ST_IDLE);
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_byte_en <= (w_state_nxt != ST_IDLE) ? 4'hF : 4'h0;
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_drop_cnt (
      .CLK   (CLK),
      .clr   (RESET),
      .inc   (w_drop),
      .count (DROP_COUNT)
   );

   assign avm.AVM_CS        = r_write;
   assign avm.AVM_WRITE     = r_write;
   assign avm.AVM_ADDR      = r_addr;
   assign avm.AVM_WRITEDATA = r_wdata;
   assign avm.AVM_BYTE_EN   = r_byte_en;
   // r_write is high exactly when the FSM is outside IDLE.
   assign BUSY              = r_write;

endmodule
`default_nettype wire
